mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register. It turns registered load/store control into a req/ack transaction on the data-memory bus and stalls the upstream pipeline until the access completes. It then loads the MEM/WB-facing output registers with the write-back bundle. Non-memory instructions pass through with one-cycle latency.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and the data memory.
// The unit drives the request side through the master modport. The memory
// answers through the slave modport.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit. It consumes the EX/MEM register and runs a
// req/ack transaction on the data-memory bus for loads and stores. While
// the access is outstanding it stalls the upstream pipeline. When the
// access completes it loads the MEM/WB-facing output registers. Non-memory
// instructions pass straight through with one cycle of latency.
//
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, an access
// whose address is not word-aligned is dropped: no request is issued, a
// bubble is written back, and misalign_fault pulses for one cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no bus activity; pass-through, or accept a new access
// BUSY  | dmem_req held high; waiting for dmem_ack or for the timeout
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RegWrite_in,
    input  logic                MemtoReg_in,
    input  logic                MemRead_in,
    input  logic                MemWrite_in,
    input  logic [31:0]         alu_result_in,
    input  logic [31:0]         write_data_in,
    input  logic [4:0]          dest_reg_in,
    mem_access_unit_if.master   dmem,
    output logic                mem_stall,
    output logic                RegWrite_out,
    output logic                MemtoReg_out,
    output logic [31:0]         read_data_out,
    output logic [31:0]         alu_result_out,
    output logic [4:0]          dest_reg_out,
    output logic                bus_error
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                misalign_fault
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Transaction latched at issue. The address doubles as the ALU result
    // that is written back.
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               is_load_q, is_load_d;
    logic               lat_rw_q, lat_rw_d;
    logic               lat_m2r_q, lat_m2r_d;
    logic [4:0]         lat_dest_q, lat_dest_d;

    // MEM/WB-facing output registers.
    logic               rw_q, rw_d;
    logic               m2r_q, m2r_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        alu_q, alu_d;
    logic [4:0]         dest_q, dest_d;
    logic               bus_err_q, bus_err_d;

    logic               access;
    logic               misaligned;
    logic               stall_c;

`ifdef MEM_ALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
    assign misaligned = (alu_result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign access = MemRead_in | MemWrite_in;

    // Next-state, latch and output-register loading for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        is_load_d  = is_load_q;
        lat_rw_d   = lat_rw_q;
        lat_m2r_d  = lat_m2r_q;
        lat_dest_d = lat_dest_q;
        rw_d       = 1'b0;
        m2r_d      = 1'b0;
        rdata_d    = 32'd0;
        alu_d      = 32'd0;
        dest_d     = 5'd0;
        bus_err_d  = bus_err_q;
        stall_c    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!access) begin
                    rw_d   = RegWrite_in;
                    m2r_d  = MemtoReg_in;
                    alu_d  = alu_result_in;
                    dest_d = dest_reg_in;
                end else if (misaligned) begin
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_d = 1'b1;
`endif
                end else begin
                    stall_c    = 1'b1;
                    addr_d     = alu_result_in;
                    wdata_d    = write_data_in;
                    // A store wins when both read and write are set.
                    we_d       = MemWrite_in;
                    is_load_d  = MemRead_in & ~MemWrite_in;
                    lat_rw_d   = RegWrite_in;
                    lat_m2r_d  = MemtoReg_in;
                    lat_dest_d = dest_reg_in;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (dmem.dmem_ack) begin
                    rw_d    = lat_rw_q;
                    m2r_d   = lat_m2r_q;
                    alu_d   = addr_q;
                    dest_d  = lat_dest_q;
                    rdata_d = is_load_q ? dmem.dmem_rdata : 32'd0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched transaction and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            is_load_q  <= 1'b0;
            lat_rw_q   <= 1'b0;
            lat_m2r_q  <= 1'b0;
            lat_dest_q <= 5'd0;
            rw_q       <= 1'b0;
            m2r_q      <= 1'b0;
            rdata_q    <= 32'd0;
            alu_q      <= 32'd0;
            dest_q     <= 5'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            is_load_q  <= is_load_d;
            lat_rw_q   <= lat_rw_d;
            lat_m2r_q  <= lat_m2r_d;
            lat_dest_q <= lat_dest_d;
            rw_q       <= rw_d;
            m2r_q      <= m2r_d;
            rdata_q    <= rdata_d;
            alu_q      <= alu_d;
            dest_q     <= dest_d;
            bus_err_q  <= bus_err_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // One-cycle misalignment pulse that accompanies the dropped access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign_fault = misalign_q;
`endif

    // The request is decoded from the registered state, so reset removes it
    // immediately. The stall is gated by reset so that the pipeline is
    // never frozen while the unit is held in reset.
    assign dmem.dmem_req   = (state_q == BUSY);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign mem_stall       = stall_c & rst_n;

    assign RegWrite_out   = rw_q;
    assign MemtoReg_out   = m2r_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign dest_reg_out   = dest_q;
    assign bus_error      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0;
    logic        MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic [31:0] alu_result_in = '0, write_data_in = '0;
    logic [4:0]  dest_reg_in = '0;
    logic        mem_stall, RegWrite_out, MemtoReg_out, bus_error;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  dest_reg_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dest;
    } wb_t;

    wb_t sb[$];

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RegWrite_in    (RegWrite_in),
        .MemtoReg_in    (MemtoReg_in),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .alu_result_in  (alu_result_in),
        .write_data_in  (write_data_in),
        .dest_reg_in    (dest_reg_in),
        .dmem           (bus),
        .mem_stall      (mem_stall),
        .RegWrite_out   (RegWrite_out),
        .MemtoReg_out   (MemtoReg_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .dest_reg_out   (dest_reg_out),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one EX/MEM instruction starting just after a falling edge and
    // acts as the memory. ack_at is the BUSY cycle index (0-based) on which
    // ack pulses; -1 means never. stray pulses ack while the unit is idle.
    // Returns after the edge that writes the instruction to MEM/WB.
    task automatic do_instr(input string tag,
                            input logic rw, input logic m2r,
                            input logic mr, input logic mw,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [4:0] dest, input int ack_at,
                            input logic [31:0] rd, input bit stray,
                            output int stall_cycles, output int req_cycles,
                            output bit bus_ok);
        wb_t e;
        wb_t got;
        int  busy_idx = 0;
        bit  done = 0;
        bit  st;
        bit  acc;
        acc = mr | mw;
        if (!acc)
            e = '{rw: rw, m2r: m2r, rd: 32'd0, alu: alu, dest: dest};
        else if (ack_at >= 0)
            e = '{rw: rw, m2r: m2r, rd: (mr && !mw) ? rd : 32'd0, alu: alu, dest: dest};
        else
            e = '0;
        sb.push_back(e);
        stall_cycles = 0;
        req_cycles   = 0;
        bus_ok       = 1;
        RegWrite_in   = rw;
        MemtoReg_in   = m2r;
        MemRead_in    = mr;
        MemWrite_in   = mw;
        alu_result_in = alu;
        write_data_in = wd;
        dest_reg_in   = dest;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (stray || (bus.dmem_req && busy_idx == ack_at)) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = stray ? 32'hFFFF_0000 : rd;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = 32'hBAD0_0000 | 32'(cyc);
            end
            #1;
            if (bus.dmem_req) begin
                req_cycles++;
                busy_idx++;
                if (bus.dmem_we !== mw || bus.dmem_addr !== alu ||
                    (mw && bus.dmem_wdata !== wd))
                    bus_ok = 0;
            end
            st = mem_stall;
            if (st) stall_cycles++;
            @(posedge clk);
            #1;
            if (!st) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        if (done) begin
            got = '{rw: RegWrite_out, m2r: MemtoReg_out, rd: read_data_out,
                    alu: alu_result_out, dest: dest_reg_out};
            e = sb.pop_front();
            chk({tag, "_RegWrite_out"}, 32'(got.rw), 32'(e.rw));
            chk({tag, "_MemtoReg_out"}, 32'(got.m2r), 32'(e.m2r));
            chk({tag, "_read_data_out"}, got.rd, e.rd);
            chk({tag, "_alu_result_out"}, got.alu, e.alu);
            chk({tag, "_dest_reg_out"}, 32'(got.dest), 32'(e.dest));
        end
        @(negedge clk);
        bus.dmem_ack = 1'b0;
    endtask

    task automatic idle_inputs();
        RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        alu_result_in = '0; write_data_in = '0; dest_reg_in = '0;
    endtask

    initial begin
        int  sc, rc;
        bit  ok;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", 32'(bus.dmem_req), 32'd0);
        chk("reset_regwrite", 32'(RegWrite_out), 32'd0);
        chk("reset_bus_error", 32'(bus_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU pass-through
        do_instr("alu", 1, 0, 0, 0, 32'h0000_00A5, 32'd0, 5'd7, -1, 32'd0, 0, sc, rc, ok);
        chk("alu_stall_cycles", 32'(sc), 32'd0);
        chk("alu_req_cycles", 32'(rc), 32'd0);

        // Load, ack in the third BUSY cycle
        do_instr("load", 1, 1, 1, 0, 32'h0000_0100, 32'd0, 5'd9, 2, 32'hDEAD_BEEF, 0, sc, rc, ok);
        chk("load_stall_cycles", 32'(sc), 32'd3);
        chk("load_req_cycles", 32'(rc), 32'd3);
        chk("load_bus_stable", 32'(ok), 32'd1);

        // Store, immediate ack
        do_instr("store", 0, 0, 0, 1, 32'h0000_0200, 32'h1234_5678, 5'd0, 0, 32'h5555_AAAA, 0, sc, rc, ok);
        chk("store_stall_cycles", 32'(sc), 32'd1);
        chk("store_req_cycles", 32'(rc), 32'd1);
        chk("store_bus", 32'(ok), 32'd1);

        // Timeout with no ack
        do_instr("timeout", 1, 1, 1, 0, 32'h0000_0300, 32'd0, 5'd4, -1, 32'd0, 0, sc, rc, ok);
        chk("timeout_req_cycles", 32'(rc), 32'd4);
        chk("timeout_stall_cycles", 32'(sc), 32'd4);
        chk("timeout_bus_error", 32'(bus_error), 32'd1);

        // Load after timeout completes normally; error stays sticky
        do_instr("load2", 1, 1, 1, 0, 32'h0000_0404, 32'd0, 5'd12, 1, 32'hCAFE_F00D, 0, sc, rc, ok);
        chk("load2_req_cycles", 32'(rc), 32'd2);
        chk("load2_bus_error_sticky", 32'(bus_error), 32'd1);

        // Store precedence when both read and write are set
        do_instr("both", 1, 0, 1, 1, 32'h0000_0508, 32'hA5A5_5A5A, 5'd3, 1, 32'h7777_7777, 0, sc, rc, ok);
        chk("both_bus_we", 32'(ok), 32'd1);

        // Stray ack while idle
        do_instr("stray", 1, 0, 0, 0, 32'h0000_0055, 32'd0, 5'd3, -1, 32'd0, 1, sc, rc, ok);
        #1;
        chk("stray_req_after", 32'(bus.dmem_req), 32'd0);

        // Back-to-back: NOP then load with zero-delay ack, min two edges
        do_instr("b2b", 1, 1, 1, 0, 32'h0000_0600, 32'd0, 5'd1, 0, 32'h0102_0304, 0, sc, rc, ok);
        chk("b2b_stall_cycles", 32'(sc), 32'd1);

        // Reset in the middle of a BUSY wait
        RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; MemWrite_in = 0;
        alu_result_in = 32'h0000_0700; dest_reg_in = 5'd5;
        bus.dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midbusy_req", 32'(bus.dmem_req), 32'd1);
        chk("midbusy_bubble", 32'(RegWrite_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_alu_out", alu_result_out, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        do_instr("post_rst", 1, 0, 0, 0, 32'h0000_0011, 32'd0, 5'd2, -1, 32'd0, 0, sc, rc, ok);
        chk("post_rst_req_cycles", 32'(rc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
